line_mem_ctrl: RTL

- Sits directly downstream of the I-/D-cache. Serves 64-bit line refills and write-backs from both caches over one shared, single-ported, 16-bit synchronous RAM.
- Arbitrates I-side and D-side line requests.
- Reads a line as 4 word beats and assembles them; writes a line as 4 word beats.
- Signals completion to the requesting cache with a one-cycle done pulse.

---
 rtl/line_mem_ctrl_pkg.sv | 41 ++++
 rtl/line_mem_ctrl_if.sv | 27 ++
 rtl/line_mem_ctrl_arbiter.sv | 30 +++
 rtl/line_mem_ctrl.sv | 125 ++++++++++++
 4 files changed

// File: rtl/line_mem_ctrl_pkg.sv
// Shared sizes, FSM/owner encodings and address helpers for the line memory controller.
package line_mem_ctrl_pkg;

  localparam int WORD_SIZE  = 16;
  localparam int LINE_WORDS = 4;
  localparam int FETCH_SIZE = WORD_SIZE * LINE_WORDS;
  localparam int BEAT_W     = 2;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WR       = 3'd1;
  localparam logic [2:0] ST_RD_ISSUE = 3'd2;
  localparam logic [2:0] ST_RD_TAIL  = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  typedef logic [WORD_SIZE-1:0]  word_t;
  typedef logic [FETCH_SIZE-1:0] line_t;
  typedef logic [BEAT_W-1:0]     beat_t;

  typedef struct packed {
    logic valid;
    logic write;
    logic owner;
  } grant_t;

  function automatic word_t line_base(input word_t addr);
    return addr & ~word_t'(LINE_WORDS - 1);
  endfunction

  // base has zero low bits, so OR-ing the beat never carries into the line index
  function automatic word_t beat_addr(input word_t base, input beat_t beat);
    return base | word_t'(beat);
  endfunction

  function automatic word_t line_word(input line_t line, input beat_t beat);
    return line[beat*WORD_SIZE +: WORD_SIZE];
  endfunction

endpackage

// File: rtl/line_mem_ctrl_if.sv
// Cache-side line request/response bundle for both the I- and D-cache ports.
interface line_mem_ctrl_if;
  import line_mem_ctrl_pkg::*;

  logic  i_readM;
  word_t i_addressM;
  line_t i_dataM;
  logic  i_doneM;

  logic  d_readM;
  logic  d_writeM;
  word_t d_addressM;
  line_t d_wdataM;
  line_t d_rdataM;
  logic  d_doneM;

  modport master (
    output i_readM, i_addressM, d_readM, d_writeM, d_addressM, d_wdataM,
    input  i_dataM, i_doneM, d_rdataM, d_doneM
  );

  modport slave (
    input  i_readM, i_addressM, d_readM, d_writeM, d_addressM, d_wdataM,
    output i_dataM, i_doneM, d_rdataM, d_doneM
  );

endinterface

// File: rtl/line_mem_ctrl_arbiter.sv
// Fixed-priority grant between D write-back, D refill and I refill, only while idle.
module line_mem_arbiter
  import line_mem_ctrl_pkg::*;
(
  input  logic   idle,
  input  logic   d_write,
  input  logic   d_read,
  input  logic   i_read,
  output grant_t grant
);

  // write-back ahead of refill keeps a dirty victim from being overwritten
  always_comb begin
    grant = '0;
    if (idle) begin
      if (d_write) begin
        grant.valid = 1'b1;
        grant.write = 1'b1;
        grant.owner = OWN_D;
      end else if (d_read) begin
        grant.valid = 1'b1;
        grant.owner = OWN_D;
      end else if (i_read) begin
        grant.valid = 1'b1;
        grant.owner = OWN_I;
      end
    end
  end

endmodule

// File: rtl/line_mem_ctrl.sv
// Line refill/write-back sequencer: one 4-beat line transaction at a time on a shared 16-bit RAM.
//
// state       | meaning
// ST_IDLE     | waiting; arbiter may grant a request this cycle
// ST_WR       | driving write beats 0..3 from the line buffer
// ST_RD_ISSUE | issuing read beats 0..3, capturing the previous beat
// ST_RD_TAIL  | capturing the last read beat
// ST_DONE     | one-cycle done pulse to the owner, no grant
module line_mem_ctrl
  import line_mem_ctrl_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  line_mem_ctrl_if.slave bus,
  output word_t          ram_addr,
  output logic           ram_we,
  output word_t          ram_wdata,
  input  word_t          ram_rdata,
  output logic           busy
);

  logic [2:0] state;
  beat_t      beat;
  beat_t      next_beat;
  logic       owner;
  word_t      base;
  word_t      grant_base;
  line_t      wbuf;
  line_t      i_line;
  line_t      d_line;
  grant_t     grant;
  logic       cap_en;
  beat_t      cap_slot;

  line_mem_arbiter u_arbiter (
    .idle    (state == ST_IDLE),
    .d_write (bus.d_writeM),
    .d_read  (bus.d_readM),
    .i_read  (bus.i_readM),
    .grant   (grant)
  );

  assign next_beat  = beat + beat_t'(1);
  assign grant_base = line_base((grant.owner == OWN_D) ? bus.d_addressM : bus.i_addressM);

  // registered RAM read: the word issued last cycle is on ram_rdata now; beat wraps to 0 in RD_TAIL
  assign cap_en   = ((state == ST_RD_ISSUE) && (beat != '0)) || (state == ST_RD_TAIL);
  assign cap_slot = beat - beat_t'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      beat      <= '0;
      owner     <= OWN_I;
      base      <= '0;
      wbuf      <= '0;
      i_line    <= '0;
      d_line    <= '0;
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant.valid) begin
            owner    <= grant.owner;
            base     <= grant_base;
            beat     <= '0;
            ram_addr <= beat_addr(grant_base, '0);
            if (grant.write) begin
              state     <= ST_WR;
              wbuf      <= bus.d_wdataM;
              ram_we    <= 1'b1;
              ram_wdata <= line_word(bus.d_wdataM, '0);
            end else begin
              state <= ST_RD_ISSUE;
            end
          end
        end
        ST_WR: begin
          beat <= next_beat;
          if (beat == beat_t'(LINE_WORDS - 1)) begin
            state     <= ST_DONE;
            ram_we    <= 1'b0;
            ram_wdata <= '0;
          end else begin
            ram_addr  <= beat_addr(base, next_beat);
            ram_wdata <= line_word(wbuf, next_beat);
          end
        end
        ST_RD_ISSUE: begin
          beat <= next_beat;
          if (beat == beat_t'(LINE_WORDS - 1)) begin
            state <= ST_RD_TAIL;
          end else begin
            ram_addr <= beat_addr(base, next_beat);
          end
        end
        ST_RD_TAIL: begin
          state <= ST_DONE;
        end
        ST_DONE: begin
          state <= ST_IDLE;
          beat  <= '0;
        end
        default: begin
          state <= ST_IDLE;
          beat  <= '0;
        end
      endcase

      if (cap_en) begin
        if (owner == OWN_D) d_line[cap_slot*WORD_SIZE +: WORD_SIZE] <= ram_rdata;
        else                i_line[cap_slot*WORD_SIZE +: WORD_SIZE] <= ram_rdata;
      end
    end
  end

  assign busy        = (state != ST_IDLE);
  assign bus.i_doneM = (state == ST_DONE) && (owner == OWN_I);
  assign bus.d_doneM = (state == ST_DONE) && (owner == OWN_D);
  assign bus.i_dataM  = i_line;
  assign bus.d_rdataM = d_line;

endmodule
